// File: rtl/w1_packer_if.sv
// Coefficient-in / packed-word-out stream bundle for w1_packer.
// The slave modport is the packer's view; master is the feeding side.
interface w1_packer_if #(
    parameter int SAMPLER_W = 4,
    parameter int SAMPLE_W  = 23,
    parameter int W         = 64
) ();
    logic                          valid_i;
    logic                          ready_i;
    logic [SAMPLER_W*SAMPLE_W-1:0] coeffs_i;
    logic                          valid_o;
    logic                          ready_o;
    logic [W-1:0]                  dout;

    modport master (
        output valid_i, coeffs_i, ready_o,
        input  ready_i, valid_o, dout
    );

    modport slave (
        input  valid_i, coeffs_i, ready_o,
        output ready_i, valid_o, dout
    );
endinterface

// File: rtl/w1_packer.sv
// Packs w1 coefficients (B bits each, little-endian bit order) into 64-bit
// words for the gen_c SHAKE256 absorb, byte 0 of the stream in dout[63:56].
module w1_packer #(
    parameter int SAMPLER_W = 4,
    parameter int SAMPLE_W  = 23,
    parameter int W         = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] sec_lvl,
    w1_packer_if.slave bus,
    output logic       done,
    output logic       range_err
);
    localparam int BUF_W    = 128;
    localparam int BEAT_MAX = SAMPLER_W * 6;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PACK = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          state, state_next;
    logic                b6, b6_next;
    logic [9:0]          total_beats, total_beats_next;
    logic [9:0]          in_cnt, in_cnt_next;
    logic [7:0]          total_words, total_words_next;
    logic [7:0]          out_cnt, out_cnt_next;
    logic [BUF_W-1:0]    buffer, buffer_next;
    logic [7:0]          fill, fill_next, base;
    logic [7:0]          beat_bits, beat_bits_next;
    logic                ready_r, ready_next;
    logic                range_err_next;
    logic                push, pop, valid, lane_bad;
    logic [BEAT_MAX-1:0] beat;
    logic                dec_ok, dec_b6;
    logic [9:0]          dec_beats;
    logic [7:0]          dec_words;

    always_comb begin
        dec_ok    = 1'b1;
        dec_b6    = 1'b0;
        dec_beats = 10'd0;
        dec_words = 8'd0;
        case (sec_lvl)
            3'd2: begin dec_b6 = 1'b1; dec_beats = 10'd256; dec_words = 8'd96;  end
            3'd3: begin                dec_beats = 10'd384; dec_words = 8'd96;  end
            3'd5: begin                dec_beats = 10'd512; dec_words = 8'd128; end
            default: dec_ok = 1'b0;
        endcase
    end

    // Range check always looks at the full lane, packing only at the low B bits.
    always_comb begin
        beat     = '0;
        lane_bad = 1'b0;
        for (int j = 0; j < SAMPLER_W; j++) begin
            if (b6)
                beat[j*6 +: 6] = bus.coeffs_i[j*SAMPLE_W +: 6];
            else
                beat[j*4 +: 4] = bus.coeffs_i[j*SAMPLE_W +: 4];
            if (bus.coeffs_i[j*SAMPLE_W +: SAMPLE_W] > (b6 ? SAMPLE_W'(43) : SAMPLE_W'(15)))
                lane_bad = 1'b1;
        end
    end

    assign valid     = (state == S_PACK) && (fill >= 8'd64);
    assign push      = bus.valid_i && ready_r;
    assign pop       = valid && bus.ready_o;
    assign beat_bits = b6 ? 8'(BEAT_MAX) : 8'(SAMPLER_W * 4);
    assign base      = pop ? fill - 8'd64 : fill;

    always_comb begin
        state_next       = state;
        b6_next          = b6;
        total_beats_next = total_beats;
        total_words_next = total_words;
        buffer_next      = (pop ? buffer >> 64 : buffer)
                         | (push ? (BUF_W'(beat) << base) : '0);
        fill_next        = base + (push ? beat_bits : 8'd0);
        in_cnt_next      = in_cnt + 10'(push);
        out_cnt_next     = out_cnt + 8'(pop);
        range_err_next   = range_err | (push & lane_bad);
        case (state)
            S_IDLE: begin
                if (start && dec_ok) begin
                    state_next       = S_PACK;
                    b6_next          = dec_b6;
                    total_beats_next = dec_beats;
                    total_words_next = dec_words;
                    buffer_next      = '0;
                    fill_next        = 8'd0;
                    in_cnt_next      = 10'd0;
                    out_cnt_next     = 8'd0;
                    range_err_next   = 1'b0;
                end
            end
            S_PACK: if (pop && out_cnt_next == total_words) state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        beat_bits_next = b6_next ? 8'(BEAT_MAX) : 8'(SAMPLER_W * 4);
        // Registered ready is evaluated on next-cycle values so it never sees ready_o.
        ready_next = (state_next == S_PACK) && (in_cnt_next < total_beats_next)
                   && (fill_next <= 8'd128 - beat_bits_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            b6          <= 1'b0;
            total_beats <= 10'd0;
            total_words <= 8'd0;
            buffer      <= '0;
            fill        <= 8'd0;
            in_cnt      <= 10'd0;
            out_cnt     <= 8'd0;
            ready_r     <= 1'b0;
            range_err   <= 1'b0;
        end else begin
            state       <= state_next;
            b6          <= b6_next;
            total_beats <= total_beats_next;
            total_words <= total_words_next;
            buffer      <= buffer_next;
            fill        <= fill_next;
            in_cnt      <= in_cnt_next;
            out_cnt     <= out_cnt_next;
            ready_r     <= ready_next;
            range_err   <= range_err_next;
        end
    end

    always_comb begin
        bus.dout = '0;
        if (valid)
            for (int k = 0; k < W/8; k++)
                bus.dout[W-1-8*k -: 8] = buffer[8*k +: 8];
    end

    assign bus.ready_i = ready_r;
    assign bus.valid_o = valid;
    assign done        = (state == S_DONE);
endmodule
